config_stream_loader: RTL
=========================

Name: config_stream_loader

Overview:
- Upstream configuration front-end for the tile array.
- Accepts a valid/ready stream of 32-bit packet words and parses per-tile packets.
- Emits one registered (config_addr, config_data, config_en) write per entry onto the shared config bus; every tile's address matchers decode that bus.
- Packet format: header word, then N pairs of (config-id word, data word).

Parameters:
- TILE_ID_W, 16, tile id width; occupies header bits [31:16] and config_addr upper bits.
- CFG_ID_W, 16, config id width; config_addr lower bits.
- DATA_W, 32, config_data width and input word width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  32  packet word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the word this cycle.
- config_addr  output  32  {tile_id, config_id}, broadcast to all tiles.
- config_data  output  32  configuration payload.
- config_en  output  1  one-cycle write strobe qualifying config_addr/config_data.
- busy  output  1  high while inside a packet (state other than HDR).
- pkt_done  output  1  one-cycle pulse after the last write of a packet.
- write_count  output  16  total writes issued since reset; wraps.
- error  output  1  sticky error flag; cleared only by reset.

Behaviour:
- A word transfers when in_valid && in_ready. in_ready is 1 in every state except RESET; there is no output backpressure.
- Reset (asynchronous, any time, including mid-packet):
  - state=HDR, remaining=0, tile_id_q=0, cfg_id_q=0.
  - config_addr=0, config_data=0, config_en=0, pkt_done=0, write_count=0, error=0.
  - Any partial packet is discarded.
- FSM:
  - HDR: on transfer, tile_id_q<=in_data[31:16] and remaining<=in_data[15:0].
    - remaining==0: stay in HDR; pulse pkt_done next cycle; no writes.
    - Otherwise go to CID.
  - CID: on transfer, cfg_id_q<=in_data[CFG_ID_W-1:0]; go to DAT. Upper bits are ignored.
  - DAT: on transfer, next cycle config_en=1, config_addr={tile_id_q,cfg_id_q}, config_data=in_data; remaining decrements; write_count increments (16-bit wrap at 0xFFFF->0).
    - remaining becomes 0: go to HDR (or CHK with the optional feature) and pulse pkt_done in the same cycle as the final config_en.
    - Otherwise go to CID.
- Latency: data word accepted at cycle t -> config_en high at t+1 for exactly 1 cycle.
- Throughput: one write per 2 accepted words.
- config_addr/config_data hold their last written value when config_en=0.
- A cycle without in_valid does not advance state; stalls are allowed anywhere in a packet.
- A new header is accepted in the cycle immediately after the last data word. Back-to-back packets have no bubble.
- tile_id 0xFFFF is passed through unchanged; broadcast handling belongs to the tiles.

Optional Feature:
- Macro: CONFIG_STREAM_LOADER_CHECKSUM_EN.
- Defined:
  - Each packet ends with one trailer word.
  - A running XOR covers all CID and DAT words of the packet and resets at each header.
  - After the last DAT the FSM enters CHK; on transfer it compares the trailer against the XOR.
  - Mismatch sets error. Writes already issued are not rolled back.
  - pkt_done pulses the cycle after the CHK transfer instead of with the last write.
  - Header count 0 goes through CHK with an expected XOR of 0.
- Undefined:
  - No CHK state, no trailer word.
  - error is tied 0.

Decomposition:
- Package config_pkg:
  - state enum (HDR, CID, DAT, CHK);
  - TILE_ID_W/CFG_ID_W/DATA_W constants;
  - header field bit positions;
  - BROADCAST_TILE_ID=16'hFFFF.
- One sub-module: config_packet_fsm, holding state, remaining counter and parse decisions. The top level holds the output registers, write_count and the checksum.

Test Plan:
- Single packet: header 0x0001_0002, then (0x5, 0xDEADBEEF), (0x7, 0x12345678) -> two config_en pulses with config_addr 0x0001_0005/0x0001_0007 and matching data; pkt_done with the second pulse; write_count=2.
- Zero-length header 0x0003_0000 followed immediately by 0x0004_0001, (0x1, 0xA5A5A5A5) -> no write for tile 3, one pkt_done for it, then a write to 0x0004_0001.
- Random in_valid gaps (50%) over 3 packets, 8 entries each -> 24 writes, order and values identical to the gap-free run, each config_en exactly 1 cycle wide.
- Reset asserted asynchronously between CID and DAT -> all outputs 0 immediately; the next header parses cleanly; the dropped entry is never written.
- write_count wrap: preload via 65536 writes -> count reads 0 after the 65536th write, and the next write gives 1.
- CHECKSUM_EN: correct trailer -> error=0; corrupted trailer (XOR^1) -> error=1 sticky across later good packets until reset.

Source files
------------

// File: rtl/config_pkg.sv
// Shared definitions for the configuration stream loader.
//
// Holds the parse-state encoding, bus field widths, header field positions
// and the checksum fold helper used when CONFIG_STREAM_LOADER_CHECKSUM_EN
// is defined.
package config_pkg;

  localparam int TILE_ID_W = 16;
  localparam int CFG_ID_W  = 16;
  localparam int DATA_W    = 32;
  localparam int COUNT_W   = 16;
  localparam int WCOUNT_W  = 16;

  // Header word layout: {tile_id, entry_count}
  localparam int HDR_TILE_MSB  = 31;
  localparam int HDR_TILE_LSB  = 16;
  localparam int HDR_COUNT_MSB = 15;
  localparam int HDR_COUNT_LSB = 0;

  // Passed through untouched; the tiles decide what broadcast means.
  localparam logic [TILE_ID_W-1:0] BROADCAST_TILE_ID = 16'hFFFF;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    CID = 2'd1,
    DAT = 2'd2,
    CHK = 2'd3
  } state_e;

  // Running checksum over the CID/DAT words of one packet.
  function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    csum_fold = acc ^ word;
  endfunction

endpackage

// File: rtl/config_packet_fsm.sv
// Packet parser for the configuration stream loader.
//
// Tracks where the loader is inside a packet (header / config id / data /
// optional trailer) and how many entries remain, and reports which kind of
// word transferred this cycle so the top level can update its registers.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid          upstream word valid
//   hdr_count         entry-count field of the current input word
//   in_ready          registered ready; low only while in reset
//   busy              high whenever the parser is not waiting for a header
//   hdr_take/cid_take/dat_take   word of that kind transferred this cycle
//   chk_take          trailer transferred (CONFIG_STREAM_LOADER_CHECKSUM_EN only)
//   pkt_end           packet completes this cycle; pkt_done follows next cycle
//
// Build option: CONFIG_STREAM_LOADER_CHECKSUM_EN adds the CHK trailer state.
module config_packet_fsm
  import config_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [COUNT_W-1:0] hdr_count,
  output logic               in_ready,
  output logic               busy,
  output logic               hdr_take,
  output logic               cid_take,
  output logic               dat_take,
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  output logic               chk_take,
`endif
  output logic               pkt_end
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               in_ready_q;
  logic               xfer;

  assign xfer     = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign busy     = (state_q != HDR);

  // Next-state and remaining-count decisions for each accepted word.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    hdr_take    = 1'b0;
    cid_take    = 1'b0;
    dat_take    = 1'b0;
    pkt_end     = 1'b0;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    chk_take    = 1'b0;
`endif
    case (state_q)
      HDR: begin
        if (xfer) begin
          hdr_take    = 1'b1;
          remaining_d = hdr_count;
          if (hdr_count == 16'd0) begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
            // An empty packet still carries a trailer (expected value 0).
            state_d = CHK;
`else
            pkt_end = 1'b1;
            state_d = HDR;
`endif
          end else begin
            state_d = CID;
          end
        end else begin
          state_d = HDR;
        end
      end
      CID: begin
        if (xfer) begin
          cid_take = 1'b1;
          state_d  = DAT;
        end else begin
          state_d = CID;
        end
      end
      DAT: begin
        if (xfer) begin
          dat_take    = 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            pkt_end = 1'b1;
            state_d = HDR;
`endif
          end else begin
            state_d = CID;
          end
        end else begin
          state_d = DAT;
        end
      end
      CHK: begin
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
        if (xfer) begin
          chk_take = 1'b1;
          pkt_end  = 1'b1;
          state_d  = HDR;
        end else begin
          state_d = CHK;
        end
`else
        state_d = HDR;
`endif
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  // Parser state, remaining-entry counter and registered ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HDR;
      remaining_q <= 16'd0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      in_ready_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/config_stream_loader.sv
// Configuration stream loader: turns a valid/ready stream of packet words
// into registered writes on the shared tile configuration bus.
//
// Packet: header {tile_id[31:16], count[15:0]}, then count pairs of
// (config-id word, data word); with CONFIG_STREAM_LOADER_CHECKSUM_EN defined
// a trailer word equal to the XOR of all config-id and data words follows.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   in_data        packet word
//   in_valid       in_data valid
//   in_ready       loader accepts a word this cycle
//   config_addr    {tile_id, config_id} of the current write
//   config_data    payload of the current write
//   config_en      one-cycle write strobe
//   busy           inside a packet
//   pkt_done       one-cycle pulse when a packet completes
//   write_count    writes since reset, wraps at 16 bits
//   error          sticky trailer-mismatch flag (tied 0 without the macro)
//
// Build option: CONFIG_STREAM_LOADER_CHECKSUM_EN enables the trailer check.
module config_stream_loader
  import config_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [TILE_ID_W+CFG_ID_W-1:0] config_addr,
  output logic [DATA_W-1:0]             config_data,
  output logic                          config_en,
  output logic                          busy,
  output logic                          pkt_done,
  output logic [WCOUNT_W-1:0]           write_count,
  output logic                          error
);

  logic hdr_take, cid_take, dat_take, pkt_end;

  logic [TILE_ID_W-1:0]          tile_id_q, tile_id_d;
  logic [CFG_ID_W-1:0]           cfg_id_q, cfg_id_d;
  logic [TILE_ID_W+CFG_ID_W-1:0] config_addr_q, config_addr_d;
  logic [DATA_W-1:0]             config_data_q, config_data_d;
  logic                          config_en_q, config_en_d;
  logic                          pkt_done_q, pkt_done_d;
  logic [WCOUNT_W-1:0]           write_count_q, write_count_d;

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  logic              chk_take;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              error_q, error_d;
`endif

  config_packet_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .hdr_count (in_data[HDR_COUNT_MSB:HDR_COUNT_LSB]),
    .in_ready  (in_ready),
    .busy      (busy),
    .hdr_take  (hdr_take),
    .cid_take  (cid_take),
    .dat_take  (dat_take),
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    .chk_take  (chk_take),
`endif
    .pkt_end   (pkt_end)
  );

  // Capture header/config-id fields and form the next bus write.
  always_comb begin
    tile_id_d     = tile_id_q;
    cfg_id_d      = cfg_id_q;
    config_addr_d = config_addr_q;
    config_data_d = config_data_q;
    config_en_d   = 1'b0;
    pkt_done_d    = pkt_end;
    write_count_d = write_count_q;
    if (hdr_take) begin
      tile_id_d = in_data[HDR_TILE_MSB:HDR_TILE_LSB];
    end else begin
      tile_id_d = tile_id_q;
    end
    if (cid_take) begin
      // Only the low config-id bits reach the bus; the rest are ignored.
      cfg_id_d = in_data[CFG_ID_W-1:0];
    end else begin
      cfg_id_d = cfg_id_q;
    end
    if (dat_take) begin
      config_en_d   = 1'b1;
      config_addr_d = {tile_id_q, cfg_id_q};
      config_data_d = in_data;
      write_count_d = write_count_q + 16'd1;
    end else begin
      config_en_d   = 1'b0;
      config_addr_d = config_addr_q;
      config_data_d = config_data_q;
      write_count_d = write_count_q;
    end
  end

  // Bus output registers and write counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_id_q     <= 16'd0;
      cfg_id_q      <= 16'd0;
      config_addr_q <= 32'd0;
      config_data_q <= 32'd0;
      config_en_q   <= 1'b0;
      pkt_done_q    <= 1'b0;
      write_count_q <= 16'd0;
    end else begin
      tile_id_q     <= tile_id_d;
      cfg_id_q      <= cfg_id_d;
      config_addr_q <= config_addr_d;
      config_data_q <= config_data_d;
      config_en_q   <= config_en_d;
      pkt_done_q    <= pkt_done_d;
      write_count_q <= write_count_d;
    end
  end

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  // Running XOR restarts at each header; trailer mismatch latches error.
  always_comb begin
    csum_d  = csum_q;
    error_d = error_q;
    if (hdr_take) begin
      csum_d = 32'd0;
    end else if (cid_take || dat_take) begin
      csum_d = csum_fold(csum_q, in_data);
    end else begin
      csum_d = csum_q;
    end
    if (chk_take && (in_data != csum_q)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  // Checksum accumulator and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q  <= 32'd0;
      error_q <= 1'b0;
    end else begin
      csum_q  <= csum_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign config_addr = config_addr_q;
  assign config_data = config_data_q;
  assign config_en   = config_en_q;
  assign pkt_done    = pkt_done_q;
  assign write_count = write_count_q;

endmodule
